// File: rtl/kbd_port_if.sv
// Register-bus interface of the keyboard port: one status and one data
// register selected by bus_sel, with one-cycle read/write strobes.
interface kbd_port_if;
   logic        bus_sel;
   logic        bus_rd;
   logic        bus_wr;
   logic [15:0] bus_wdata;
   logic [15:0] bus_rdata;

   modport master (
      output bus_sel,
      output bus_rd,
      output bus_wr,
      output bus_wdata,
      input  bus_rdata
   );

   modport slave (
      input  bus_sel,
      input  bus_rd,
      input  bus_wr,
      input  bus_wdata,
      output bus_rdata
   );
endinterface

// File: rtl/kbd_port.sv
// UKNC-style keyboard port: takes keycodes from an upstream scanner through
// a press_btn/read handshake and buffers them in a small FIFO. The CPU side
// sees them through status (177700) and data (177702) registers. A two-state
// FSM drives a level interrupt that stays quiet after an acknowledge until
// the CPU pops a code or re-enables interrupts.
module kbd_port #(
   parameter int DEPTH = 4
) (
   input  logic       clk50,
   input  logic       rst,
   input  logic       press_btn,
   input  logic [7:0] keycode,
   output logic       read,
   kbd_port_if.slave  bus,
   output logic       irq,
   input  logic       irq_ack
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_REQ  = 1'b1;

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic          r_read;
   logic          r_blank;
   logic          r_ovf;
   logic          r_ie;
   logic          r_armed;
   logic [15:0]   r_rdata;
   logic [0:0]    r_state;
   logic [0:0]    w_state_nxt;

   logic          w_full;
   logic          w_empty;
   logic          w_offer;
   logic          w_null;
   logic          w_accept;
   logic          w_push;
   logic          w_overflow;
   logic          w_pop;
   logic          w_reg_wr;
   logic          w_ie_rise;
   logic [15:0]   w_status;

   assign w_full  = (r_count == CW'(DEPTH));
   assign w_empty = (r_count == '0);

   // Upstream is only looked at outside the read pulse and the blank cycle
   // after it, so a press_btn that has not yet dropped is never taken twice.
   assign w_offer    = press_btn & ~r_read & ~r_blank;
   assign w_null     = (keycode == 8'h00);
   assign w_accept   = w_offer & (w_null | ~w_full);
   assign w_push     = w_accept & ~w_null;
   assign w_overflow = w_offer & ~w_null & w_full;

   assign w_pop     = bus.bus_rd & bus.bus_sel & ~w_empty;
   // A read strobe wins over a simultaneous write strobe.
   assign w_reg_wr  = bus.bus_wr & ~bus.bus_rd & ~bus.bus_sel;
   assign w_ie_rise = w_reg_wr & bus.bus_wdata[6] & ~r_ie;

   assign w_status = {r_ovf, 7'b0, ~w_empty, r_ie, 6'b0};

   assign read          = r_read;
   assign irq           = (r_state == ST_REQ);
   assign bus.bus_rdata = r_rdata;

   // Upstream handshake: one-cycle read acknowledge followed by a blank cycle.
   always_ff @(posedge clk50 or negedge rst) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of block ordering.
      if (!rst) begin
         r_read  <= 1'b0;
         r_blank <= 1'b0;
      end else begin
         r_read  <= w_accept;
         r_blank <= r_read;
      end
   end

   // FIFO storage; contents are only meaningful below the count.
   // NOTE: the storage array has no reset so it maps onto plain RAM/regfile
   // cells; pointers and count alone define what is valid.
   always_ff @(posedge clk50) begin
      if (w_push) r_mem[r_wptr] <= keycode;
   end

   // FIFO pointers and occupancy count.
   always_ff @(posedge clk50 or negedge rst) begin
      if (!rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Control bits: sticky overflow and interrupt enable.
   always_ff @(posedge clk50 or negedge rst) begin
      if (!rst) begin
         r_ovf <= 1'b0;
         r_ie  <= 1'b0;
      end else begin
         if (w_reg_wr) r_ie <= bus.bus_wdata[6];
         // A fresh overflow in the same cycle as a clear keeps the flag set.
         if (w_overflow)                        r_ovf <= 1'b1;
         else if (w_reg_wr && bus.bus_wdata[15]) r_ovf <= 1'b0;
      end
   end

   // Registered read data; held between read strobes.
   always_ff @(posedge clk50 or negedge rst) begin
      if (!rst) begin
         r_rdata <= 16'h0000;
      end else if (bus.bus_rd) begin
         if (!bus.bus_sel)  r_rdata <= w_status;
         else if (!w_empty) r_rdata <= {8'h00, r_mem[r_rptr]};
         else               r_rdata <= 16'h0000;
      end
   end

   // Interrupt FSM next-state logic.
   always_comb begin
      // NOTE: default assignment first so no path leaves the signal unassigned
      // and no latch is inferred.
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (r_ie && !w_empty && r_armed)     w_state_nxt = ST_REQ;
         ST_REQ:  if (irq_ack || !r_ie || w_empty)     w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Interrupt FSM state and re-arm flag: an acknowledge disarms the request
   // until a pop or a 0->1 write of IE.
   always_ff @(posedge clk50 or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_armed <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         if (w_pop || w_ie_rise)              r_armed <= 1'b1;
         else if (r_state == ST_REQ && irq_ack) r_armed <= 1'b0;
      end
   end

endmodule

// File: tb/tb_kbd_port.sv
// Directed testbench for kbd_port (DEPTH=4): handshake, FIFO ordering,
// overflow, interrupt behaviour and reset.
module tb_kbd_port;

   logic       clk50 = 1'b0;
   logic       rst;
   logic       press_btn;
   logic [7:0] keycode;
   logic       read;
   logic       irq;
   logic       irq_ack;

   int n_total = 0;
   int n_bad   = 0;

   kbd_port_if bus_if ();

   kbd_port #(.DEPTH(4)) u_dut (
      .clk50     (clk50),
      .rst       (rst),
      .press_btn (press_btn),
      .keycode   (keycode),
      .read      (read),
      .bus       (bus_if.slave),
      .irq       (irq),
      .irq_ack   (irq_ack)
   );

   always #5 clk50 = ~clk50;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk50);
      #1;
   endtask

   task automatic reg_read(input logic sel, output logic [15:0] val);
      bus_if.bus_sel = sel;
      bus_if.bus_rd  = 1'b1;
      step();
      bus_if.bus_rd  = 1'b0;
      val = bus_if.bus_rdata;
   endtask

   task automatic reg_write(input logic [15:0] data);
      bus_if.bus_sel   = 1'b0;
      bus_if.bus_wdata = data;
      bus_if.bus_wr    = 1'b1;
      step();
      bus_if.bus_wr    = 1'b0;
   endtask

   // Upstream model: hold press_btn until read is seen, then drop it.
   task automatic push(input logic [7:0] code);
      logic seen;
      seen      = 1'b0;
      press_btn = 1'b1;
      keycode   = code;
      for (int i = 0; i < 20 && !seen; i++) begin
         step();
         if (read) seen = 1'b1;
      end
      press_btn = 1'b0;
      check("push_ack", {15'b0, seen}, 16'h0001);
      step();
      check("read_width", {15'b0, read}, 16'h0000);
      step();
   endtask

   logic [15:0] v;
   logic        seen;

   initial begin
      rst              = 1'b0;
      press_btn        = 1'b0;
      keycode          = 8'h00;
      irq_ack          = 1'b0;
      bus_if.bus_sel   = 1'b0;
      bus_if.bus_rd    = 1'b0;
      bus_if.bus_wr    = 1'b0;
      bus_if.bus_wdata = 16'h0000;

      // Reset state
      step();
      step();
      check("rst_read",  {15'b0, read}, 16'h0000);
      check("rst_irq",   {15'b0, irq},  16'h0000);
      check("rst_rdata", bus_if.bus_rdata, 16'h0000);
      rst = 1'b1;
      step();

      // Single keycode 8'o072
      push(8'o072);
      reg_read(1'b0, v); check("s1_status_rdy", v, 16'h0080);
      reg_read(1'b1, v); check("s1_data",       v, 16'h003A);
      reg_read(1'b0, v); check("s1_status_emp", v, 16'h0000);

      // Empty data read, null keycode
      reg_read(1'b1, v); check("empty_data",   v, 16'h0000);
      reg_read(1'b0, v); check("empty_status", v, 16'h0000);
      push(8'h00);
      reg_read(1'b0, v); check("null_no_push", v, 16'h0000);

      // Overflow with DEPTH=4
      push(8'h11);
      push(8'h22);
      push(8'h33);
      push(8'h44);
      press_btn = 1'b1;
      keycode   = 8'h55;
      seen      = 1'b0;
      repeat (6) begin
         step();
         if (read) seen = 1'b1;
      end
      check("full_hold", {15'b0, seen}, 16'h0000);
      reg_read(1'b0, v); check("ovf_status", v, 16'h8080);
      reg_read(1'b1, v); check("ovf_pop",    v, 16'h0011);
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         step();
         if (read) seen = 1'b1;
      end
      press_btn = 1'b0;
      check("fifth_accept", {15'b0, seen}, 16'h0001);
      step();
      step();
      reg_read(1'b0, v); check("ovf_sticky", v, 16'h8080);
      reg_write(16'h8000);
      reg_read(1'b0, v); check("ovf_clear", v, 16'h0080);
      reg_read(1'b1, v); check("drain_22", v, 16'h0022);
      reg_read(1'b1, v); check("drain_33", v, 16'h0033);
      reg_read(1'b1, v); check("drain_44", v, 16'h0044);
      reg_read(1'b1, v); check("drain_55", v, 16'h0055);
      reg_read(1'b0, v); check("drain_emp", v, 16'h0000);

      // Interrupt behaviour
      reg_write(16'h0040);
      reg_read(1'b0, v); check("ie_status", v, 16'h0040);
      check("irq_idle", {15'b0, irq}, 16'h0000);
      press_btn = 1'b1;
      keycode   = 8'h8A;
      step();
      check("irq_push_read", {15'b0, read}, 16'h0001);
      check("irq_push_edge", {15'b0, irq},  16'h0000);
      press_btn = 1'b0;
      step();
      check("irq_raise", {15'b0, irq}, 16'h0001);
      irq_ack = 1'b1;
      step();
      irq_ack = 1'b0;
      check("irq_ack_drop", {15'b0, irq}, 16'h0000);
      step();
      step();
      step();
      check("irq_no_rearm", {15'b0, irq}, 16'h0000);
      reg_read(1'b1, v); check("irq_pop", v, 16'h008A);
      step();
      check("irq_empty", {15'b0, irq}, 16'h0000);
      push(8'h05);
      check("irq_next_push", {15'b0, irq}, 16'h0001);

      // Push and pop in the same cycle at count=2
      push(8'h06);
      press_btn      = 1'b1;
      keycode        = 8'h07;
      bus_if.bus_sel = 1'b1;
      bus_if.bus_rd  = 1'b1;
      step();
      bus_if.bus_rd  = 1'b0;
      press_btn      = 1'b0;
      check("pp_read", {15'b0, read}, 16'h0001);
      check("pp_data", bus_if.bus_rdata, 16'h0005);
      step();
      step();
      reg_read(1'b0, v); check("pp_status", v, 16'h00C0);
      reg_read(1'b1, v); check("pp_order_06", v, 16'h0006);
      reg_read(1'b1, v); check("pp_order_07", v, 16'h0007);
      reg_read(1'b0, v); check("pp_empty",    v, 16'h0040);

      // Asynchronous reset mid-operation
      push(8'hA1);
      push(8'hA2);
      push(8'hA3);
      check("pre_rst_irq", {15'b0, irq}, 16'h0001);
      reg_read(1'b0, v); check("pre_rst_status", v, 16'h00C0);
      #2;
      rst = 1'b0;
      #1;
      check("arst_irq",   {15'b0, irq},  16'h0000);
      check("arst_read",  {15'b0, read}, 16'h0000);
      check("arst_rdata", bus_if.bus_rdata, 16'h0000);
      step();
      step();
      rst = 1'b1;
      step();
      reg_read(1'b0, v); check("post_rst_status", v, 16'h0000);
      reg_read(1'b1, v); check("post_rst_data",   v, 16'h0000);
      check("post_rst_irq", {15'b0, irq}, 16'h0000);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/kbd_port.md
KBD_PORT -- requirements
Module: kbd_port

Interface
REQ-001 SHALL have parameter DEPTH, default 4, keycode FIFO depth (power of two, 2..16).
REQ-002 SHALL have port clk50, input, 1, sole clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port press_btn, input, 1, upstream keycode-available level, held until read.
REQ-005 SHALL have port keycode, input, 8, upstream code: bit7=1 release, bits6:0 UKNC key number.
REQ-006 SHALL have port read, output, 1, one-cycle acknowledge to upstream; keycode consumed.
REQ-007 SHALL have port bus_sel, input, 1, register select: 0 = status (177700), 1 = data (177702).
REQ-008 SHALL have port bus_rd, input, 1, one-cycle register read strobe.
REQ-009 SHALL have port bus_wr, input, 1, one-cycle register write strobe.
REQ-010 SHALL have port bus_wdata, input, 16, write data.
REQ-011 SHALL have port bus_rdata, output, 16, registered read data.
REQ-012 SHALL have port irq, output, 1, keyboard interrupt request, level.
REQ-013 SHALL have port irq_ack, input, 1, one-cycle interrupt vector acknowledge.

Function
REQ-014 SHALL accept upstream data: when press_btn=1, FIFO not full, and not in blank cycle, push keycode and assert read for exactly one cycle.
REQ-015 SHALL treat the cycle after any read pulse as a blank cycle with no push, covering upstream negedge clear of press_btn.
REQ-016 SHALL, when FIFO full and press_btn=1, leave read low (no loss, upstream holds) and set sticky status bit15 OVF.
REQ-017 SHALL ignore press_btn when keycode=8'h00; read SHALL still pulse to discard it.
REQ-018 SHALL hold FIFO as DEPTH x 8 with wrapping read/write pointers and a count 0..DEPTH; full = count==DEPTH, empty = count==0.
REQ-019 SHALL form the status word as: bit15 OVF, bit7 RDY (=~empty), bit6 IE; other bits read 0.
REQ-020 SHALL, on bus_rd with bus_sel=0, load the status word into bus_rdata on the next edge (1-cycle latency).
REQ-021 SHALL, on bus_rd with bus_sel=1 and FIFO non-empty, load {8'h00, head} into bus_rdata and pop on the same edge.
REQ-022 SHALL, on data read with FIFO empty, return 16'h0000 and leave pointers unchanged.
REQ-023 SHALL, on push and pop in the same cycle, perform both with count unchanged; on push and pop at count 0, pop returns 0 and count becomes 1.
REQ-024 SHALL, on bus_wr with bus_sel=0, set IE from bus_wdata[6] and clear OVF if bus_wdata[15]=1.
REQ-025 SHALL ignore writes to bus_sel=1.
REQ-026 SHALL hold bus_rdata unchanged when no bus_rd occurs.
REQ-027 SHALL treat simultaneous bus_rd and bus_wr as a read only.
REQ-028 SHALL run an irq FSM with states IDLE and REQ:
  - IDLE->REQ when IE=1 and RDY=1.
  - REQ->IDLE on irq_ack, or when IE=0 or RDY=0.
  - irq=1 only in REQ.
REQ-029 SHALL, after irq_ack, stay in IDLE until a pop occurs or IE toggles 0->1, then re-arm on the IDLE->REQ rule.
REQ-030 SHALL give irq a latency of 1 cycle after the push edge that makes RDY=1 (IE=1).

Reset
REQ-031 SHALL, while rst=0, force:
  - FIFO pointers and count = 0
  - OVF = 0, IE = 0
  - read = 0, bus_rdata = 16'h0000, irq = 0
  - FSM = IDLE, blank flag = 0
REQ-032 SHALL, on reset mid-operation, discard FIFO contents and resume on the first edge after rst rises.

Verification
REQ-033 SHALL cover: press_btn=1 with keycode=8'o072 -> read one-cycle pulse, status read = 16'h0080, data read = 16'h003A, then status = 16'h0000.
REQ-034 SHALL cover: push 5 codes with DEPTH=4 and no pops -> 4 read pulses, 5th held with read low, OVF=1; one pop -> 5th accepted; status write 16'h8000 -> OVF=0.
REQ-035 SHALL cover: IE=1, push 8'h8A -> irq=1 one cycle later; irq_ack -> irq=0 with no re-assert; data read pops; next push -> irq=1.
REQ-036 SHALL cover: push and data read in the same cycle at count=2 -> count stays 2 and FIFO order is preserved.
REQ-037 SHALL cover: data read when empty -> bus_rdata=16'h0000, count stays 0; keycode=8'h00 with press_btn=1 -> read pulse, no push.
REQ-038 SHALL cover: rst asserted with 3 entries and irq=1 -> all outputs 0 asynchronously; after release, status reads 16'h0000.
